// File: rtl/legv8_cache_pkg.sv
// Shared types and default widths for the LEGv8 cache controller slice.
package legv8_cache_pkg;

  localparam int unsigned ADDR_W_DEF   = 64;
  localparam int unsigned INDEX_W_DEF  = 5;
  localparam int unsigned OFFSET_W_DEF = 2;
  localparam int unsigned TAG_W_DEF    = ADDR_W_DEF - INDEX_W_DEF - OFFSET_W_DEF;
  localparam int unsigned TMO_W        = 8;
  localparam int unsigned STAT_W       = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_MEM    = 3'd2,
    ST_FILL   = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/legv8_cache_controller_if.sv
// CPU, cache-set and memory handshake bundle; master = controller side.
interface legv8_cache_controller_if
  import legv8_cache_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned INDEX_W  = INDEX_W_DEF,
  parameter int unsigned OFFSET_W = OFFSET_W_DEF
);

  localparam int unsigned TAG_W = ADDR_W - OFFSET_W - INDEX_W;

  logic               cpu_req;
  logic [ADDR_W-1:0]  cpu_addr;
  logic               cpu_ready;
  logic               cpu_hit;
  logic               cpu_err;
  logic               busy;

  logic [INDEX_W-1:0] set_index;
  logic [TAG_W-1:0]   set_tag;
  logic               set_write;
  logic               set_hit;

  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;

  modport master (
    input  cpu_req, cpu_addr, set_hit, mem_ack,
    output cpu_ready, cpu_hit, cpu_err, busy,
    output set_index, set_tag, set_write,
    output mem_req, mem_addr
  );

  modport slave (
    output cpu_req, cpu_addr, set_hit, mem_ack,
    input  cpu_ready, cpu_hit, cpu_err, busy,
    input  set_index, set_tag, set_write,
    input  mem_req, mem_addr
  );

endinterface

// File: rtl/legv8_cache_stats.sv
// Saturating hit/miss counters sampled on the CPU response pulse.
// Only instantiated when LEGV8_CACHE_STATS_EN is defined.
module legv8_cache_stats
  import legv8_cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rsp_valid,
  input  logic              rsp_hit,
  input  logic              rsp_err,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count
);

  logic [STAT_W-1:0] hit_count_q, hit_count_d;
  logic [STAT_W-1:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (rsp_valid && rsp_hit && (hit_count_q != '1)) begin
      hit_count_d = hit_count_q + STAT_W'(1);
    end
    // Timeouts are neither hits nor misses.
    if (rsp_valid && !rsp_hit && !rsp_err && (miss_count_q != '1)) begin
      miss_count_d = miss_count_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: rtl/legv8_cache_controller.sv
// LEGv8 cache sequencing controller: lookup, miss fetch, tag fill, CPU response.
// Optional hit/miss statistics ports under LEGV8_CACHE_STATS_EN.
module legv8_cache_controller
  import legv8_cache_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned INDEX_W     = INDEX_W_DEF,
  parameter int unsigned OFFSET_W    = OFFSET_W_DEF,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  legv8_cache_controller_if.master  bus
`ifdef LEGV8_CACHE_STATS_EN
  ,
  output logic [STAT_W-1:0]         hit_count,
  output logic [STAT_W-1:0]         miss_count
`endif
);

  localparam int unsigned TAG_W = ADDR_W - OFFSET_W - INDEX_W;
  localparam logic [ADDR_W-1:0] BLOCK_MASK = ~(ADDR_W'((64'd1 << OFFSET_W) - 64'd1));
  localparam logic [TMO_W-1:0]  TMO_LIMIT  = TMO_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hit_q, hit_d;
  logic              err_q, err_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  cnt_inc;

  logic cpu_ready_q, cpu_ready_d;
  logic cpu_hit_q, cpu_hit_d;
  logic cpu_err_q, cpu_err_d;
  logic busy_q, busy_d;
  logic mem_req_q, mem_req_d;
  logic set_write_q, set_write_d;

  assign cnt_inc = cnt_q + TMO_W'(1);

  // Next-state logic; outputs are registered from the next state so each
  // output is high exactly in the cycles its state is occupied.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hit_d   = hit_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          hit_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (bus.set_hit) begin
          hit_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d   = '0;
          state_d = ST_MEM;
        end
      end
      ST_MEM: begin
        // A completing ack wins over a timeout landing in the same cycle.
        if (bus.mem_ack) begin
          state_d = ST_FILL;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TMO_LIMIT) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_FILL: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cpu_ready_d = (state_d == ST_RESP);
    cpu_hit_d   = (state_d == ST_RESP) && hit_d;
    cpu_err_d   = (state_d == ST_RESP) && err_d;
    busy_d      = (state_d != ST_IDLE);
    mem_req_d   = (state_d == ST_MEM);
    set_write_d = (state_d == ST_FILL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      hit_q       <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      cpu_ready_q <= 1'b0;
      cpu_hit_q   <= 1'b0;
      cpu_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      set_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      hit_q       <= hit_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_hit_q   <= cpu_hit_d;
      cpu_err_q   <= cpu_err_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      set_write_q <= set_write_d;
    end
  end

  // Set lookup fields and fetch address are slices of the captured address.
  assign bus.set_index = addr_q[OFFSET_W +: INDEX_W];
  assign bus.set_tag   = addr_q[ADDR_W-1 -: TAG_W];
  assign bus.mem_addr  = addr_q & BLOCK_MASK;

  assign bus.cpu_ready = cpu_ready_q;
  assign bus.cpu_hit   = cpu_hit_q;
  assign bus.cpu_err   = cpu_err_q;
  assign bus.busy      = busy_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.set_write = set_write_q;

`ifdef LEGV8_CACHE_STATS_EN
  legv8_cache_stats u_stats (
    .clk        (clk),
    .rst        (rst),
    .rsp_valid  (cpu_ready_q),
    .rsp_hit    (cpu_hit_q),
    .rsp_err    (cpu_err_q),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );
`endif

endmodule

// File: tb/tb_legv8_cache_controller.sv
// Directed self-checking bench for legv8_cache_controller with a behavioural cache-set model.
module tb_legv8_cache_controller;
  import legv8_cache_pkg::*;

  localparam int unsigned TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  legv8_cache_controller_if bus ();

`ifdef LEGV8_CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  legv8_cache_controller #(.MEM_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef LEGV8_CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // Cache set model: valid bits plus tag store, combinational hit.
  logic [31:0]          mdl_valid = '0;
  logic [TAG_W_DEF-1:0] mdl_tag [32];
  int                   wr_cnt = 0;

  assign bus.set_hit = mdl_valid[bus.set_index] && (mdl_tag[bus.set_index] == bus.set_tag);

  always @(posedge clk) begin
    if (bus.set_write) begin
      mdl_valid[bus.set_index] <= 1'b1;
      mdl_tag[bus.set_index]   <= bus.set_tag;
      wr_cnt                   <= wr_cnt + 1;
    end
  end

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a request in an IDLE cycle (cycle 0); returns in cycle 1.
  task automatic start(input logic [63:0] a);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = a;
    tick();
    bus.cpu_req  = 1'b0;
  endtask

  initial begin
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = '0;
    bus.mem_ack  = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);

    check("rst_ready", 64'(bus.cpu_ready), 64'd0);
    check("rst_hit", 64'(bus.cpu_hit), 64'd0);
    check("rst_err", 64'(bus.cpu_err), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_memreq", 64'(bus.mem_req), 64'd0);
    check("rst_setwr", 64'(bus.set_write), 64'd0);
    check("rst_memaddr", bus.mem_addr, 64'd0);
    check("rst_index", 64'(bus.set_index), 64'd0);
    check("rst_tag", 64'(bus.set_tag), 64'd0);
`ifdef LEGV8_CACHE_STATS_EN
    check("rst_hitcnt", 64'(hit_count), 64'd0);
    check("rst_misscnt", 64'(miss_count), 64'd0);
`endif
    rst = 1'b1;
    tick();

    // Cold miss at 0x104, ack in the 3rd MEM cycle.
    start(64'h104);
    check("miss_c1_busy", 64'(bus.busy), 64'd1);
    check("miss_c1_index", 64'(bus.set_index), 64'd1);
    check("miss_c1_tag", 64'(bus.set_tag), 64'd2);
    check("miss_c1_memreq", 64'(bus.mem_req), 64'd0);
    tick();
    check("miss_c2_memreq", 64'(bus.mem_req), 64'd1);
    check("miss_c2_memaddr", bus.mem_addr, 64'h104);
    tick();
    tick();
    check("miss_c4_memreq", 64'(bus.mem_req), 64'd1);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("miss_c5_setwr", 64'(bus.set_write), 64'd1);
    check("miss_c5_memreq", 64'(bus.mem_req), 64'd0);
    check("miss_c5_ready", 64'(bus.cpu_ready), 64'd0);
    check("miss_c5_index", 64'(bus.set_index), 64'd1);
    check("miss_c5_tag", 64'(bus.set_tag), 64'd2);
    tick();
    check("miss_c6_ready", 64'(bus.cpu_ready), 64'd1);
    check("miss_c6_hit", 64'(bus.cpu_hit), 64'd0);
    check("miss_c6_err", 64'(bus.cpu_err), 64'd0);
    check("miss_c6_setwr", 64'(bus.set_write), 64'd0);
    check("miss_writes", 64'(wr_cnt), 64'd1);
    tick();
    check("miss_c7_ready", 64'(bus.cpu_ready), 64'd0);
    check("miss_c7_busy", 64'(bus.busy), 64'd0);

    // Same address again hits.
    start(64'h104);
    check("hit_c1_memreq", 64'(bus.mem_req), 64'd0);
    check("hit_c1_ready", 64'(bus.cpu_ready), 64'd0);
    tick();
    check("hit_c2_ready", 64'(bus.cpu_ready), 64'd1);
    check("hit_c2_hit", 64'(bus.cpu_hit), 64'd1);
    check("hit_c2_memreq", 64'(bus.mem_req), 64'd0);
    tick();

    // Timeout at 0x208: no ack for 4 MEM cycles, then a late ack.
    start(64'h208);
    tick();
    tick();
    tick();
    tick();
    check("tmo_c5_memreq", 64'(bus.mem_req), 64'd1);
    check("tmo_c5_ready", 64'(bus.cpu_ready), 64'd0);
    tick();
    check("tmo_c6_ready", 64'(bus.cpu_ready), 64'd1);
    check("tmo_c6_err", 64'(bus.cpu_err), 64'd1);
    check("tmo_c6_hit", 64'(bus.cpu_hit), 64'd0);
    check("tmo_c6_memreq", 64'(bus.mem_req), 64'd0);
    check("tmo_writes", 64'(wr_cnt), 64'd1);
    tick();
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("late_ack_busy", 64'(bus.busy), 64'd0);
    check("late_ack_setwr", 64'(bus.set_write), 64'd0);
    check("late_ack_writes", 64'(wr_cnt), 64'd1);

    // Ack arrives in the same MEM cycle the timeout would fire.
    start(64'h30C);
    tick();
    tick();
    tick();
    tick();
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("edge_c6_setwr", 64'(bus.set_write), 64'd1);
    check("edge_c6_ready", 64'(bus.cpu_ready), 64'd0);
    check("edge_c6_index", 64'(bus.set_index), 64'd3);
    tick();
    check("edge_c7_ready", 64'(bus.cpu_ready), 64'd1);
    check("edge_c7_err", 64'(bus.cpu_err), 64'd0);
    check("edge_c7_hit", 64'(bus.cpu_hit), 64'd0);
    check("edge_writes", 64'(wr_cnt), 64'd2);
    tick();

    // cpu_req held across two hits: accepted every 3 cycles, not in RESP.
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 64'h104;
    tick();
    check("b2b_c1_busy", 64'(bus.busy), 64'd1);
    tick();
    check("b2b_c2_ready", 64'(bus.cpu_ready), 64'd1);
    check("b2b_c2_hit", 64'(bus.cpu_hit), 64'd1);
    tick();
    check("b2b_c3_busy", 64'(bus.busy), 64'd0);
    check("b2b_c3_ready", 64'(bus.cpu_ready), 64'd0);
    tick();
    check("b2b_c4_busy", 64'(bus.busy), 64'd1);
    tick();
    check("b2b_c5_ready", 64'(bus.cpu_ready), 64'd1);
    check("b2b_c5_hit", 64'(bus.cpu_hit), 64'd1);
    bus.cpu_req = 1'b0;
    tick();
    check("b2b_c6_busy", 64'(bus.busy), 64'd0);
    tick();
    check("b2b_c7_busy", 64'(bus.busy), 64'd0);
`ifdef LEGV8_CACHE_STATS_EN
    check("stats_hits", 64'(hit_count), 64'd3);
    check("stats_misses", 64'(miss_count), 64'd2);
`endif

    // Asynchronous reset while in MEM.
    start(64'h40C);
    tick();
    check("arst_pre_memreq", 64'(bus.mem_req), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_memreq", 64'(bus.mem_req), 64'd0);
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_ready", 64'(bus.cpu_ready), 64'd0);
    check("arst_memaddr", bus.mem_addr, 64'd0);
`ifdef LEGV8_CACHE_STATS_EN
    check("arst_hitcnt", 64'(hit_count), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post_rst_busy", 64'(bus.busy), 64'd0);
    start(64'h104);
    check("post_rst_c1_busy", 64'(bus.busy), 64'd1);
    check("post_rst_c1_index", 64'(bus.set_index), 64'd1);
    tick();
    check("post_rst_c2_ready", 64'(bus.cpu_ready), 64'd1);
    check("post_rst_c2_hit", 64'(bus.cpu_hit), 64'd1);
    tick();
`ifdef LEGV8_CACHE_STATS_EN
    check("post_rst_hitcnt", 64'(hit_count), 64'd1);
    check("post_rst_misscnt", 64'(miss_count), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
